modn_updown_counter_cfg: RTL and testbench
==========================================

// Module: modn_updown_counter_cfg
// PURPOSE
//   Parametrised mod-N up/down counter, successor to the fixed 4-bit mod-N up/down counter.
//   Adds configurable width, modulus and step, plus enable, synchronous load, and three
//   boundary modes: wrap, saturate and one-shot. Boundary events come out as pulses.
//   Used as a timebase/sequence counter inside control datapaths.
// PARAMETERS
//   WIDTH      4   count width in bits; 2^WIDTH >= MODULUS
//   MODULUS    10  count range 0..MODULUS-1; must be 2..2^WIDTH
//   STEP       1   increment/decrement per enabled cycle; must be 1..MODULUS-1
//   RESET_VAL  0   count value after reset; must be < MODULUS
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous reset, active-high
//   en        in   1      count enable
//   up        in   1      1 = count up, 0 = count down; sampled each enabled cycle
//   mode      in   2      00 wrap, 01 saturate, 10 one-shot, 11 reserved (acts as wrap)
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value to load
//   count     out  WIDTH  current count (registered)
//   tc        out  1      combinational: count == MODULUS-1 when up=1, count == 0 when up=0
//   ovf       out  1      registered 1-cycle pulse: an up step crossed MODULUS-1
//   unf       out  1      registered 1-cycle pulse: a down step crossed below 0
//   stopped   out  1      registered: one-shot has hit its boundary and is halted
//   load_err  out  1      registered 1-cycle pulse: load_val >= MODULUS was clamped
// BEHAVIOUR
//   Reset (async, takes effect immediately and holds while high):
//     count=RESET_VAL, stopped=0, ovf=unf=load_err=0.
//   Priority per rising edge: reset > load > en. When no strobe is active, count holds.
//   Load:
//     count <= min(load_val, MODULUS-1) and stopped <= 0.
//     load_err=1 for that cycle only when clamped.
//     ovf and unf are 0 on a load cycle, even if en is also 1.
//   Enabled step (en=1, load=0, stopped=0):
//     Arithmetic is done in WIDTH+1 bits, so nothing overflows internally.
//     Up, no crossing (count+STEP <= MODULUS-1): count <= count+STEP.
//     Down, no crossing (count >= STEP): count <= count-STEP.
//     Up crossing:
//       wrap: count <= count+STEP-MODULUS.
//       saturate: count <= MODULUS-1.
//       one-shot: count <= MODULUS-1, stopped <= 1.
//       ovf=1 next cycle in all modes, including saturate while already at MODULUS-1.
//     Down crossing:
//       wrap: count <= count+MODULUS-STEP.
//       saturate: count <= 0.
//       one-shot: count <= 0, stopped <= 1.
//       unf=1 next cycle in all modes.
//   en=1 while stopped=1: count holds, no pulses. Only load or reset clear stopped.
//   Direction may change on any cycle with no penalty; the new up value is used that edge.
//   Mode may change on any cycle. A change to wrap or saturate does not clear stopped.
//   Latency: 1 clock from an enabled edge to count, ovf, unf and stopped. tc follows
//     count and up combinationally.
//   Count state: RUN (stopped=0) and HALT (stopped=1).
//     RUN -> HALT on a one-shot crossing.
//     HALT -> RUN on load.
//     reset -> RUN.
// TESTING (WIDTH=4, MODULUS=10, STEP=1 unless noted)
//   1. Reset, mode=00, up=1, en=1 for 12 clks.
//      -> count 0..9,0,1; ovf high only the cycle count=0 after 9; tc=1 while count=9.
//   2. Load 0, then up=0, en=1.
//      -> count 9,8,...; unf pulses once on 0->9; tc=1 while count=0.
//   3. mode=01, load 8, up=1, en=1 for 4 clks.
//      -> count 9,9,9,9; ovf high on the last 3 cycles; count never wraps.
//   4. mode=10, load 7, up=1, en=1.
//      -> 8,9 then stopped=1, count frozen at 9 despite en.
//      -> load_val=3 with load=1 -> count=3, stopped=0, counting resumes.
//   5. load=1, load_val=12 -> count=9, load_err for exactly 1 cycle.
//      -> load=1 with en=1, load_val=4 -> count=4; the step is ignored, no ovf/unf.
//   6. STEP=3, wrap, up from 0: 0,3,6,9,2 (ovf on 9->2).
//      -> async reset asserted mid-cycle at count=6 -> count=0 before the next clk edge.

Source files
------------

// File: rtl/modn_updown_counter_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : modn_updown_counter_cfg
//  Purpose  : Parametrised mod-N up/down counter with enable, synchronous load,
//             and wrap / saturate / one-shot boundary modes with event pulses.
//  Revision : 1.0  initial release
// ============================================================================
module modn_updown_counter_cfg #(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 10,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf,
   output logic             stopped,
   output logic             load_err
);

   localparam logic [WIDTH:0]   c_mod       = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   c_step      = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] c_max       = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

   localparam logic [1:0] c_mode_wrap    = 2'b00;
   localparam logic [1:0] c_mode_sat     = 2'b01;
   localparam logic [1:0] c_mode_oneshot = 2'b10;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic             r_unf;
   logic             r_load_err;

   logic [WIDTH:0]   w_count_ext;
   logic [WIDTH:0]   w_up_sum;
   logic             w_up_cross;
   logic             w_dn_cross;
   logic [WIDTH-1:0] w_up_wrap;
   logic [WIDTH-1:0] w_dn_wrap;
   logic [WIDTH-1:0] w_dn_diff;
   logic             w_load_over;
   logic [WIDTH-1:0] w_load_clamped;

   // All step arithmetic is one bit wider than the count so it cannot overflow.
   assign w_count_ext    = {1'b0, r_count};
   assign w_up_sum       = w_count_ext + c_step;
   assign w_up_cross     = (w_up_sum > {1'b0, c_max});
   assign w_dn_cross     = (w_count_ext < c_step);
   assign w_up_wrap      = WIDTH'(w_up_sum - c_mod);
   assign w_dn_wrap      = WIDTH'(w_count_ext + c_mod - c_step);
   assign w_dn_diff      = WIDTH'(w_count_ext - c_step);
   assign w_load_over    = ({1'b0, load_val} >= c_mod);
   assign w_load_clamped = w_load_over ? c_max : load_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RUN;
         r_count    <= c_reset_val;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_load_err <= 1'b0;
         if (load) begin
            r_count    <= w_load_clamped;
            r_load_err <= w_load_over;
            r_state    <= RUN;
         end else if (en && (r_state == RUN)) begin
            if (up) begin
               if (w_up_cross) begin
                  // Saturate still flags ovf even when already sitting at the top.
                  r_ovf <= 1'b1;
                  case (mode)
                     c_mode_sat: r_count <= c_max;
                     c_mode_oneshot: begin
                        r_count <= c_max;
                        r_state <= HALT;
                     end
                     default: r_count <= w_up_wrap;
                  endcase
               end else begin
                  r_count <= w_up_sum[WIDTH-1:0];
               end
            end else begin
               if (w_dn_cross) begin
                  r_unf <= 1'b1;
                  case (mode)
                     c_mode_sat: r_count <= '0;
                     c_mode_oneshot: begin
                        r_count <= '0;
                        r_state <= HALT;
                     end
                     default: r_count <= w_dn_wrap;
                  endcase
               end else begin
                  r_count <= w_dn_diff;
               end
            end
         end
      end
   end

   assign count    = r_count;
   assign ovf      = r_ovf;
   assign unf      = r_unf;
   assign load_err = r_load_err;
   assign stopped  = (r_state == HALT);
   assign tc       = up ? (r_count == c_max) : (r_count == '0);

   // c_mode_wrap documents the default branch encoding (00 and 11 both wrap).
   logic w_mode_is_wrap;
   assign w_mode_is_wrap = (mode == c_mode_wrap);

   logic w_unused;
   assign w_unused = w_mode_is_wrap;

endmodule
`default_nettype wire

// File: tb/tb_modn_updown_counter_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modn_updown_counter_cfg
//  Purpose  : Directed self-checking bench for modn_updown_counter_cfg
//             (STEP=1 instance a, STEP=3 instance b).
//  Revision : 1.0  initial release
// ============================================================================
module tb_modn_updown_counter_cfg;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // Instance a: WIDTH=4, MODULUS=10, STEP=1
   logic       a_reset, a_en, a_up, a_load;
   logic [1:0] a_mode;
   logic [3:0] a_load_val, a_count;
   logic       a_tc, a_ovf, a_unf, a_stopped, a_load_err;

   // Instance b: WIDTH=4, MODULUS=10, STEP=3
   logic       b_reset, b_en, b_up, b_load;
   logic [1:0] b_mode;
   logic [3:0] b_load_val, b_count;
   logic       b_tc, b_ovf, b_unf, b_stopped, b_load_err;

   modn_updown_counter_cfg #(.WIDTH(4), .MODULUS(10), .STEP(1), .RESET_VAL(0)) u_a (
      .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .mode(a_mode),
      .load(a_load), .load_val(a_load_val), .count(a_count), .tc(a_tc),
      .ovf(a_ovf), .unf(a_unf), .stopped(a_stopped), .load_err(a_load_err)
   );

   modn_updown_counter_cfg #(.WIDTH(4), .MODULUS(10), .STEP(3), .RESET_VAL(0)) u_b (
      .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .mode(b_mode),
      .load(b_load), .load_val(b_load_val), .count(b_count), .tc(b_tc),
      .ovf(b_ovf), .unf(b_unf), .stopped(b_stopped), .load_err(b_load_err)
   );

   // Advance one clock and settle 1 ns past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_reset = 1'b1; a_en = 1'b0; a_up = 1'b1; a_load = 1'b0;
      a_mode = 2'b00; a_load_val = 4'd0;
      b_reset = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0;
      b_mode = 2'b00; b_load_val = 4'd0;
      tick();
      tick();
      total++;
      if (a_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", a_count);
      else passed++;
      total++;
      if ({a_ovf, a_unf, a_stopped, a_load_err} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {a_ovf, a_unf, a_stopped, a_load_err});
      else passed++;
      a_reset = 1'b0;
      b_reset = 1'b0;
   endtask

   task automatic test_wrap_up();
      int exp_c;
      a_mode = 2'b00; a_up = 1'b1; a_en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_c = i % 10;
         total++;
         if (a_count !== 4'(exp_c)) $display("FAIL wrap_up_count[%0d]: got %0d want %0d", i, a_count, exp_c);
         else passed++;
         total++;
         if (a_ovf !== (i == 10)) $display("FAIL wrap_up_ovf[%0d]: got %b want %b", i, a_ovf, (i == 10));
         else passed++;
         total++;
         if (a_tc !== (exp_c == 9)) $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, a_tc, (exp_c == 9));
         else passed++;
      end
      a_en = 1'b0;
   endtask

   task automatic test_wrap_down();
      int exp_c;
      a_load = 1'b1; a_load_val = 4'd0; a_up = 1'b0;
      tick();
      a_load = 1'b0;
      total++;
      if (a_tc !== 1'b1) $display("FAIL down_tc_at_zero: got %b want 1", a_tc);
      else passed++;
      a_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_c = (20 - i) % 10;
         total++;
         if (a_count !== 4'(exp_c)) $display("FAIL wrap_dn_count[%0d]: got %0d want %0d", i, a_count, exp_c);
         else passed++;
         total++;
         if (a_unf !== (i == 1)) $display("FAIL wrap_dn_unf[%0d]: got %b want %b", i, a_unf, (i == 1));
         else passed++;
      end
      total++;
      if (a_tc !== 1'b1) $display("FAIL wrap_dn_tc: got %b want 1", a_tc);
      else passed++;
      a_en = 1'b0;
   endtask

   task automatic test_saturate();
      a_mode = 2'b01; a_load = 1'b1; a_load_val = 4'd8; a_up = 1'b1;
      tick();
      a_load = 1'b0; a_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (a_count !== 4'd9) $display("FAIL sat_count[%0d]: got %0d want 9", i, a_count);
         else passed++;
         total++;
         if (a_ovf !== (i > 1)) $display("FAIL sat_ovf[%0d]: got %b want %b", i, a_ovf, (i > 1));
         else passed++;
      end
      a_en = 1'b0;
   endtask

   task automatic test_oneshot();
      a_mode = 2'b10; a_load = 1'b1; a_load_val = 4'd7; a_up = 1'b1;
      tick();
      a_load = 1'b0; a_en = 1'b1;
      tick();
      tick();
      total++;
      if ({a_count, a_stopped} !== {4'd9, 1'b0}) $display("FAIL os_pre: got %0d/%b want 9/0", a_count, a_stopped);
      else passed++;
      tick();
      total++;
      if ({a_count, a_stopped, a_ovf} !== {4'd9, 1'b1, 1'b1})
         $display("FAIL os_hit: got %0d/%b/%b want 9/1/1", a_count, a_stopped, a_ovf);
      else passed++;
      a_mode = 2'b00;
      tick();
      total++;
      if ({a_count, a_stopped, a_ovf} !== {4'd9, 1'b1, 1'b0})
         $display("FAIL os_frozen: got %0d/%b/%b want 9/1/0", a_count, a_stopped, a_ovf);
      else passed++;
      a_en = 1'b0; a_load = 1'b1; a_load_val = 4'd3;
      tick();
      a_load = 1'b0; a_en = 1'b1;
      total++;
      if ({a_count, a_stopped} !== {4'd3, 1'b0}) $display("FAIL os_reload: got %0d/%b want 3/0", a_count, a_stopped);
      else passed++;
      tick();
      total++;
      if (a_count !== 4'd4) $display("FAIL os_resume: got %0d want 4", a_count);
      else passed++;
      a_en = 1'b0;
   endtask

   task automatic test_load_clamp();
      a_mode = 2'b00; a_load = 1'b1; a_load_val = 4'd12;
      tick();
      a_load = 1'b0;
      total++;
      if ({a_count, a_load_err} !== {4'd9, 1'b1}) $display("FAIL clamp: got %0d/%b want 9/1", a_count, a_load_err);
      else passed++;
      tick();
      total++;
      if ({a_count, a_load_err} !== {4'd9, 1'b0}) $display("FAIL clamp_pulse: got %0d/%b want 9/0", a_count, a_load_err);
      else passed++;
      // At 9 counting up, an unmasked step would overflow; load must win.
      a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_load_val = 4'd4;
      tick();
      a_load = 1'b0; a_en = 1'b0;
      total++;
      if ({a_count, a_ovf, a_unf, a_load_err} !== {4'd4, 3'b000})
         $display("FAIL load_over_en: got %0d/%b%b%b want 4/000", a_count, a_ovf, a_unf, a_load_err);
      else passed++;
   endtask

   task automatic test_back_to_back();
      a_en = 1'b1;
      a_up = 1'b1; tick();
      a_up = 1'b0; tick();
      total++;
      if (a_count !== 4'd4) $display("FAIL dir_flip_down: got %0d want 4", a_count);
      else passed++;
      a_up = 1'b0; tick();
      a_up = 1'b1; tick();
      total++;
      if (a_count !== 4'd4) $display("FAIL dir_flip_up: got %0d want 4", a_count);
      else passed++;
      a_en = 1'b0;
   endtask

   task automatic test_step3();
      logic [3:0] exp_seq [4];
      exp_seq = '{4'd3, 4'd6, 4'd9, 4'd2};
      b_mode = 2'b00; b_up = 1'b1; b_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (b_count !== exp_seq[i]) $display("FAIL step3_count[%0d]: got %0d want %0d", i, b_count, exp_seq[i]);
         else passed++;
         total++;
         if (b_ovf !== (i == 3)) $display("FAIL step3_ovf[%0d]: got %b want %b", i, b_ovf, (i == 3));
         else passed++;
      end
      b_en = 1'b0; b_load = 1'b1; b_load_val = 4'd1; b_up = 1'b0;
      tick();
      b_load = 1'b0; b_en = 1'b1;
      tick();
      total++;
      if ({b_count, b_unf} !== {4'd8, 1'b1}) $display("FAIL step3_dn_wrap: got %0d/%b want 8/1", b_count, b_unf);
      else passed++;
      b_en = 1'b0; b_load = 1'b1; b_load_val = 4'd0; b_up = 1'b1;
      tick();
      b_load = 1'b0; b_en = 1'b1;
      tick();
      tick();
      b_en = 1'b0;
      total++;
      if (b_count !== 4'd6) $display("FAIL step3_pre_reset: got %0d want 6", b_count);
      else passed++;
      #2 b_reset = 1'b1;
      #1;
      total++;
      if (b_count !== 4'd0) $display("FAIL async_reset: got %0d want 0", b_count);
      else passed++;
      tick();
      b_reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_oneshot();
      test_load_clamp();
      test_back_to_back();
      test_step3();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
